// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends N frames of a fixed MSB-first pattern,
// separated by idle-high gap bits, with registered outputs throughout.
module seq_pattern_tx #(
    parameter int                   PAT_LEN    = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN    = 4'b0110,
    parameter int                   MAX_FRAMES = 5,
    parameter int                   CNT_W      = 3,
    parameter int                   GAP_BITS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_frames,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PAT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_BITS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FRAMES);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   frames_sent_q, frames_sent_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   req;
    logic [PAT_LEN-1:0] pat_bits;

    genvar gi;
    generate
        for (gi = 0; gi < PAT_LEN; gi++) begin : g_pat
            assign pat_bits[gi] = PATTERN[gi];
        end
    endgenerate

    assign req = (num_frames > MAX_CNT) ? MAX_CNT : num_frames;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            gap_q         <= '0;
            rem_q         <= '0;
            frames_sent_q <= '0;
            out_q         <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            rem_q         <= rem_d;
            frames_sent_q <= frames_sent_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        rem_d         = rem_q;
        frames_sent_d = frames_sent_q;
        case (state_q)
            IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    frames_sent_d = '0;
                    if (req != '0) begin
                        state_d = SEND;
                        idx_d   = IDX_MAX;
                        rem_d   = req;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    frames_sent_d = (frames_sent_q == MAX_CNT) ? MAX_CNT
                                                               : frames_sent_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end else if (GAP_BITS > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end else begin
                        idx_d   = IDX_MAX;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    state_d = SEND;
                    idx_d   = IDX_MAX;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        out_d        = (state_d == SEND) ? pat_bits[idx_d] : 1'b1;
        out_valid_d  = (state_d == SEND);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == SEND) && (idx_d == '0);
        done_d       = ((state_q == IDLE) && start && !abort && (req == '0)) ||
                       ((state_q == SEND) && !abort && (idx_q == '0) && (rem_q == CNT_W'(1)));
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign done        = done_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench: vector table for cycle-exact sequences plus hand-written
// loops for long requests and the back-to-back (no gap) variant.
module tb_seq_pattern_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, abort_a, start_b, abort_b;
    logic [2:0] nf_a, nf_b;
    logic       out_a, out_valid_a, busy_a, frame_done_a, done_a;
    logic       out_b, out_valid_b, busy_b, frame_done_b, done_b;
    logic [2:0] fs_a, fs_b;

    seq_pattern_tx dut_a (
        .clk(clk), .rst(rst), .start(start_a), .num_frames(nf_a), .abort(abort_a),
        .out(out_a), .out_valid(out_valid_a), .busy(busy_a),
        .frame_done(frame_done_a), .done(done_a), .frames_sent(fs_a)
    );

    seq_pattern_tx #(.GAP_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_frames(nf_b), .abort(abort_b),
        .out(out_b), .out_valid(out_valid_b), .busy(busy_b),
        .frame_done(frame_done_b), .done(done_b), .frames_sent(fs_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference detector: shifts only valid bits, counts 0110 hits
    logic [3:0] det_sh  = 4'b0000;
    int         det_cnt = 0;
    always @(posedge clk) begin
        if (out_valid_a) begin
            det_sh <= {det_sh[2:0], out_a};
            if ({det_sh[2:0], out_a} == 4'b0110) det_cnt <= det_cnt + 1;
        end
    end

    typedef struct {
        logic       rst;
        logic       start;
        logic [2:0] nf;
        logic       abort;
        logic [4:0] exp;     // {out, out_valid, busy, frame_done, done}
        logic [2:0] exp_fs;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic [2:0] n,
                                input logic a, input logic [4:0] e,
                                input logic [2:0] f, input string nm);
        vec_t v;
        v.rst = r; v.start = s; v.nf = n; v.abort = a;
        v.exp = e; v.exp_fs = f; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            $display("ok   %s value=%0h", name, got);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; start_a = vecs[i].start;
            nf_a = vecs[i].nf; abort_a = vecs[i].abort;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].name, i),
                  {24'd0, out_a, out_valid_a, busy_a, frame_done_a, done_a, fs_a},
                  {24'd0, vecs[i].exp, vecs[i].exp_fs});
        end
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0; abort_a = 1'b0; nf_a = 3'd0;
        vecs.delete();
    endtask

    int det_start;
    int n_valid, n_fd, n_done;
    logic [3:0] pat;

    initial begin
        rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; nf_a = 3'd0;
        start_b = 1'b0; abort_b = 1'b0; nf_b = 3'd0;
        pat = 4'b0110;

        // Reset then idle; start during reset must be ignored
        add(1, 1, 3'd2, 0, 5'b10000, 3'd0, "reset");
        add(1, 0, 3'd0, 0, 5'b10000, 3'd0, "reset");
        for (int i = 0; i < 5; i++) add(0, 0, 3'd0, 0, 5'b10000, 3'd0, "idle");
        run_vecs();
        check("b_reset", {29'd0, out_b, out_valid_b, busy_b}, {29'd0, 3'b100});

        // Two frames with a 2-bit gap; start while busy is ignored
        det_start = det_cnt;
        add(0, 1, 3'd2, 0, 5'b01100, 3'd0, "two");
        add(0, 1, 3'd1, 0, 5'b11100, 3'd0, "two");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd0, "two");
        add(0, 0, 3'd0, 0, 5'b01110, 3'd0, "two");
        add(0, 0, 3'd0, 0, 5'b10100, 3'd1, "two");
        add(0, 0, 3'd0, 0, 5'b10100, 3'd1, "two");
        add(0, 0, 3'd0, 0, 5'b01100, 3'd1, "two");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd1, "two");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd1, "two");
        add(0, 0, 3'd0, 0, 5'b01110, 3'd1, "two");
        add(0, 0, 3'd0, 0, 5'b10001, 3'd2, "two");
        add(0, 0, 3'd0, 0, 5'b10000, 3'd2, "two");
        run_vecs();
        check("detections", det_cnt - det_start, 2);

        // Zero frames: immediate done; start in the done cycle is accepted
        add(0, 1, 3'd0, 0, 5'b10001, 3'd0, "zero");
        add(0, 1, 3'd1, 0, 5'b01100, 3'd0, "in_done");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd0, "in_done");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd0, "in_done");
        add(0, 0, 3'd0, 0, 5'b01110, 3'd0, "in_done");
        add(0, 0, 3'd0, 0, 5'b10001, 3'd1, "in_done");
        add(0, 0, 3'd0, 0, 5'b10000, 3'd1, "in_done");
        run_vecs();

        // Abort on the 2nd bit of frame 2; abort+start in IDLE does nothing
        add(0, 1, 3'd3, 0, 5'b01100, 3'd0, "abort");
        add(0, 1, 3'd5, 0, 5'b11100, 3'd0, "abort");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd0, "abort");
        add(0, 0, 3'd0, 0, 5'b01110, 3'd0, "abort");
        add(0, 0, 3'd0, 0, 5'b10100, 3'd1, "abort");
        add(0, 0, 3'd0, 0, 5'b10100, 3'd1, "abort");
        add(0, 0, 3'd0, 0, 5'b01100, 3'd1, "abort");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd1, "abort");
        add(0, 0, 3'd0, 1, 5'b10000, 3'd1, "abort");
        add(0, 0, 3'd0, 0, 5'b10000, 3'd1, "abort");
        add(0, 1, 3'd2, 1, 5'b10000, 3'd1, "abort_start");
        add(0, 0, 3'd0, 0, 5'b10000, 3'd1, "abort_start");
        run_vecs();

        // Reset mid-SEND, then a clean single frame
        add(0, 1, 3'd2, 0, 5'b01100, 3'd0, "rst_mid");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd0, "rst_mid");
        add(1, 1, 3'd3, 1, 5'b10000, 3'd0, "rst_mid");
        add(0, 1, 3'd1, 0, 5'b01100, 3'd0, "after_rst");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd0, "after_rst");
        add(0, 0, 3'd0, 0, 5'b11100, 3'd0, "after_rst");
        add(0, 0, 3'd0, 0, 5'b01110, 3'd0, "after_rst");
        add(0, 0, 3'd0, 0, 5'b10001, 3'd1, "after_rst");
        run_vecs();

        // num_frames above the cap: exactly MAX_FRAMES frames
        n_valid = 0; n_fd = 0; n_done = 0;
        @(negedge clk); start_a = 1'b1; nf_a = 3'd7;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (out_valid_a)  n_valid++;
            if (frame_done_a) n_fd++;
            if (done_a)       n_done++;
        end
        check("cap_valid_bits", n_valid, 20);
        check("cap_frame_done", n_fd, 5);
        check("cap_done", n_done, 1);
        check("cap_frames_sent", {29'd0, fs_a}, 5);

        // Back-to-back frames with no gap
        @(negedge clk); start_b = 1'b1; nf_b = 3'd3;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            check($sformatf("nogap_bit[%0d]", i),
                  {29'd0, out_b, out_valid_b, frame_done_b},
                  {29'd0, pat[3 - (i % 4)], 1'b1, (i % 4) == 3});
        end
        @(posedge clk);
        #1;
        check("nogap_end", {28'd0, done_b, busy_b, fs_b}, {28'd0, 1'b1, 1'b0, 3'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
